// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multi-cycle sequencer for the RV32 subset R_ALU, I_ALU,
// LOAD, STORE, BRANCH and JAL. It drives the per-state strobes for PC, IR,
// MDR, the register file, the ALU and a shared instruction/data memory port.
// The memory port uses a req/ready handshake with a wait-cycle timeout.
//
// Ports:
//   clk, rst          clock (rising edge), synchronous active-high reset
//   opcode[6:0]       IR[6:0]; valid from DECODE onward
//   branch_taken      datapath comparator result, used in EXEC
//   mem_ready         memory completes the current access this cycle
//   mem_req, mem_we   memory request and write enable
//   addr_sel          memory address: 0 = PC, 1 = ALU result
//   ir_write          load IR and OLD_PC
//   mdr_write         load MDR from memory read data
//   pc_write, pc_src  PC update; source 0 = PC+4, 1 = OLD_PC+imm
//   alu_op[2:0]       000 add, 001 branch cmp, 010 R-type, 011 I-type, 100 idle
//   alu_src           0 = rs2, 1 = immediate
//   imm_sel[1:0]      00 I/L, 01 S, 10 B, 11 J
//   reg_write         register file write strobe
//   wb_sel[1:0]       00 ALU, 01 MDR, 10 OLD_PC+4
//   halted            sticky trap indication
//   state_o[2:0]      current state code (debug)
module multicycle_ctrl #(
   parameter int unsigned MEM_TIMEOUT = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] opcode,
   input  logic       branch_taken,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       mem_we,
   output logic       addr_sel,
   output logic       ir_write,
   output logic       mdr_write,
   output logic       pc_write,
   output logic       pc_src,
   output logic [2:0] alu_op,
   output logic       alu_src,
   output logic [1:0] imm_sel,
   output logic       reg_write,
   output logic [1:0] wb_sel,
   output logic       halted,
   output logic [2:0] state_o
);

   typedef enum logic [2:0] {
      FETCH  = 3'd0,
      DECODE = 3'd1,
      EXEC   = 3'd2,
      MEM    = 3'd3,
      WB     = 3'd4,
      TRAP   = 3'd5
   } state_t;

   localparam logic [6:0] OP_R_ALU  = 7'b0110011;
   localparam logic [6:0] OP_I_ALU  = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   localparam logic [7:0] WAIT_LIMIT = 8'(MEM_TIMEOUT - 1);

   state_t     state;
   state_t     state_next;
   logic [7:0] wait_cnt;
   logic       mem_wait;
   logic       timeout;

   // A wait cycle is any FETCH/MEM cycle where the memory has not answered.
   assign mem_wait = ((state == FETCH) || (state == MEM)) && !mem_ready;
   assign timeout  = mem_wait && (wait_cnt == WAIT_LIMIT);

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= FETCH;
         wait_cnt <= '0;
      end else begin
         state <= state_next;
         if (state_next != state) begin
            wait_cnt <= '0;
         end else if (mem_wait) begin
            wait_cnt <= wait_cnt + 8'd1;
         end
      end
   end

   assign state_o = rst ? 3'd0 : state;

   always_comb begin
      state_next = state;
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      addr_sel   = 1'b0;
      ir_write   = 1'b0;
      mdr_write  = 1'b0;
      pc_write   = 1'b0;
      pc_src     = 1'b0;
      alu_op     = 3'b100;
      alu_src    = 1'b0;
      imm_sel    = 2'b00;
      reg_write  = 1'b0;
      wb_sel     = 2'b00;
      halted     = 1'b0;

      // Outputs are forced to their idle values while rst is asserted so an
      // in-flight access is abandoned without firing any strobe.
      if (!rst) begin
         case (state)
            FETCH: begin
               mem_req = 1'b1;
               if (mem_ready) begin
                  ir_write   = 1'b1;
                  pc_write   = 1'b1;
                  state_next = DECODE;
               end else if (timeout) begin
                  state_next = TRAP;
               end
            end
            DECODE: begin
               case (opcode)
                  OP_STORE:  imm_sel = 2'b01;
                  OP_BRANCH: imm_sel = 2'b10;
                  OP_JAL:    imm_sel = 2'b11;
                  default:   imm_sel = 2'b00;
               endcase
               case (opcode)
                  OP_R_ALU, OP_I_ALU, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL:
                     state_next = EXEC;
                  default:
                     state_next = TRAP;
               endcase
            end
            EXEC: begin
               case (opcode)
                  OP_R_ALU: begin
                     alu_op     = 3'b010;
                     state_next = WB;
                  end
                  OP_I_ALU: begin
                     alu_op     = 3'b011;
                     alu_src    = 1'b1;
                     state_next = WB;
                  end
                  OP_LOAD, OP_STORE: begin
                     alu_op     = 3'b000;
                     alu_src    = 1'b1;
                     imm_sel    = (opcode == OP_STORE) ? 2'b01 : 2'b00;
                     state_next = MEM;
                  end
                  OP_BRANCH: begin
                     alu_op     = 3'b001;
                     imm_sel    = 2'b10;
                     pc_src     = 1'b1;
                     pc_write   = branch_taken;
                     state_next = FETCH;
                  end
                  OP_JAL: begin
                     imm_sel    = 2'b11;
                     pc_src     = 1'b1;
                     pc_write   = 1'b1;
                     reg_write  = 1'b1;
                     wb_sel     = 2'b10;
                     state_next = FETCH;
                  end
                  default: state_next = TRAP;
               endcase
            end
            MEM: begin
               mem_req  = 1'b1;
               addr_sel = 1'b1;
               mem_we   = (opcode == OP_STORE);
               alu_op   = 3'b000;
               alu_src  = 1'b1;
               imm_sel  = (opcode == OP_STORE) ? 2'b01 : 2'b00;
               if (mem_ready) begin
                  if (opcode == OP_LOAD) begin
                     mdr_write  = 1'b1;
                     state_next = WB;
                  end else begin
                     state_next = FETCH;
                  end
               end else if (timeout) begin
                  state_next = TRAP;
               end
            end
            WB: begin
               reg_write = 1'b1;
               case (opcode)
                  OP_R_ALU: alu_op = 3'b010;
                  OP_I_ALU: begin
                     alu_op  = 3'b011;
                     alu_src = 1'b1;
                  end
                  OP_LOAD: begin
                     alu_op  = 3'b000;
                     alu_src = 1'b1;
                     wb_sel  = 2'b01;
                  end
                  default: ;
               endcase
               state_next = FETCH;
            end
            TRAP: begin
               halted = 1'b1;
            end
            default: state_next = TRAP;
         endcase
      end
   end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized self-checking bench for multicycle_ctrl. A reference model expands
// each instruction into its expected sequence of phases (memory waits, timeout
// trap, write-back) and the expected strobe set is compared every cycle.
module tb_multicycle_ctrl;

   localparam int unsigned TO = 4;

   localparam logic [6:0] R_ALU  = 7'b0110011;
   localparam logic [6:0] I_ALU  = 7'b0010011;
   localparam logic [6:0] LOAD   = 7'b0000011;
   localparam logic [6:0] STORE  = 7'b0100011;
   localparam logic [6:0] BRANCH = 7'b1100011;
   localparam logic [6:0] JAL    = 7'b1101111;

   logic       clk = 1'b0;
   logic       rst;
   logic [6:0] opcode;
   logic       branch_taken;
   logic       mem_ready;
   logic       mem_req, mem_we, addr_sel, ir_write, mdr_write, pc_write, pc_src;
   logic [2:0] alu_op;
   logic       alu_src;
   logic [1:0] imm_sel;
   logic       reg_write;
   logic [1:0] wb_sel;
   logic       halted;
   logic [2:0] state_o;

   typedef struct packed {
      logic       mem_req;
      logic       mem_we;
      logic       addr_sel;
      logic       ir_write;
      logic       mdr_write;
      logic       pc_write;
      logic       pc_src;
      logic [2:0] alu_op;
      logic       alu_src;
      logic [1:0] imm_sel;
      logic       reg_write;
      logic [1:0] wb_sel;
      logic       halted;
      logic [2:0] state;
   } obs_t;

   typedef struct {
      int unsigned st;
      bit          rdy;
   } step_t;

   obs_t        obs;
   step_t       tr[$];
   int          n_checks = 0;
   int          n_errors = 0;
   string       st_name[6] = '{"fetch", "decode", "exec", "mem", "wb", "trap"};

   always #5 clk = ~clk;

   multicycle_ctrl #(.MEM_TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .opcode(opcode), .branch_taken(branch_taken),
      .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
      .addr_sel(addr_sel), .ir_write(ir_write), .mdr_write(mdr_write),
      .pc_write(pc_write), .pc_src(pc_src), .alu_op(alu_op), .alu_src(alu_src),
      .imm_sel(imm_sel), .reg_write(reg_write), .wb_sel(wb_sel),
      .halted(halted), .state_o(state_o)
   );

   assign obs = {mem_req, mem_we, addr_sel, ir_write, mdr_write, pc_write, pc_src,
                 alu_op, alu_src, imm_sel, reg_write, wb_sel, halted, state_o};

   task automatic check(input string tag, input obs_t act, input obs_t exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %05h expected %05h", tag, act, exp);
      end
   endtask

   function automatic bit is_legal(input logic [6:0] op);
      return op inside {R_ALU, I_ALU, LOAD, STORE, BRANCH, JAL};
   endfunction

   // Expected outputs for one cycle, straight from the per-state rules.
   function automatic obs_t expect_out(input int unsigned st, input logic [6:0] op,
                                       input bit rdy, input bit tk);
      obs_t e;
      e        = '0;
      e.alu_op = 3'b100;
      e.state  = 3'(st);
      if (st == 0) begin
         e.mem_req  = 1'b1;
         e.ir_write = rdy;
         e.pc_write = rdy;
      end else if (st == 1) begin
         e.imm_sel = (op == STORE) ? 2'b01 : (op == BRANCH) ? 2'b10 :
                     (op == JAL) ? 2'b11 : 2'b00;
      end else if (st == 3) begin
         e.mem_req   = 1'b1;
         e.addr_sel  = 1'b1;
         e.mem_we    = (op == STORE);
         e.alu_op    = 3'b000;
         e.alu_src   = 1'b1;
         e.imm_sel   = (op == STORE) ? 2'b01 : 2'b00;
         e.mdr_write = rdy && (op == LOAD);
      end else if (st == 5) begin
         e.halted = 1'b1;
      end else begin
         // EXEC and WB share the ALU setup so the result is stable into WB.
         if (op == R_ALU) e.alu_op = 3'b010;
         if (op == I_ALU) begin e.alu_op = 3'b011; e.alu_src = 1'b1; end
         if (op == LOAD || op == STORE) begin e.alu_op = 3'b000; e.alu_src = 1'b1; end
         if (st == 2) begin
            if (op == STORE) e.imm_sel = 2'b01;
            if (op == BRANCH) begin
               e.alu_op = 3'b001; e.imm_sel = 2'b10; e.pc_src = 1'b1; e.pc_write = tk;
            end
            if (op == JAL) begin
               e.imm_sel = 2'b11; e.pc_src = 1'b1; e.pc_write = 1'b1;
               e.reg_write = 1'b1; e.wb_sel = 2'b10;
            end
         end else begin
            e.reg_write = 1'b1;
            e.wb_sel    = (op == LOAD) ? 2'b01 : 2'b00;
         end
      end
      return e;
   endfunction

   task automatic add_step(input int unsigned st, input bit rdy);
      step_t s;
      s.st  = st;
      s.rdy = rdy;
      tr.push_back(s);
   endtask

   // A memory phase: w wait cycles then ready, or TO silent cycles then trap.
   task automatic add_access(input int unsigned st, input int unsigned w, output bit trapped);
      trapped = (w >= TO);
      repeat (trapped ? TO : w) add_step(st, 1'b0);
      if (!trapped) add_step(st, 1'b1);
   endtask

   task automatic do_reset();
      obs_t e;
      e        = '0;
      e.alu_op = 3'b100;
      rst = 1'b1;
      repeat (3) begin
         mem_ready    = 1'b1;
         opcode       = 7'($urandom);
         branch_taken = 1'($urandom);
         @(negedge clk);
         check("reset", obs, e);
         @(posedge clk);
         #1;
      end
      rst = 1'b0;
   endtask

   task automatic run_instr(input logic [6:0] op, input int unsigned wf,
                            input int unsigned wm, input bit tk);
      bit trapped;
      tr.delete();
      add_access(0, wf, trapped);
      if (!trapped) begin
         add_step(1, 1'($urandom));
         if (!is_legal(op)) begin
            trapped = 1'b1;
         end else begin
            add_step(2, 1'($urandom));
            if (op == LOAD || op == STORE) add_access(3, wm, trapped);
            if (!trapped && (op == R_ALU || op == I_ALU || op == LOAD))
               add_step(4, 1'($urandom));
         end
      end
      if (trapped) repeat (20) add_step(5, 1'($urandom));
      foreach (tr[i]) begin
         opcode       = op;
         mem_ready    = tr[i].rdy;
         branch_taken = (tr[i].st == 2) ? tk : 1'($urandom);
         @(negedge clk);
         check(st_name[tr[i].st], obs, expect_out(tr[i].st, op, tr[i].rdy, branch_taken));
         @(posedge clk);
         #1;
      end
      if (trapped) do_reset();
   endtask

   initial begin
      logic [6:0]  legal_ops[6] = '{R_ALU, I_ALU, LOAD, STORE, BRANCH, JAL};
      logic [6:0]  op;
      int unsigned wf, wm;
      rst          = 1'b1;
      mem_ready    = 1'b1;
      opcode       = '0;
      branch_taken = 1'b0;
      #1;
      do_reset();

      run_instr(R_ALU, 0, 0, 1'b0);
      run_instr(LOAD, 0, 2, 1'b0);
      run_instr(STORE, 0, 0, 1'b0);
      run_instr(BRANCH, 0, 0, 1'b1);
      run_instr(BRANCH, 0, 0, 1'b0);
      run_instr(JAL, 0, 0, 1'b0);
      run_instr(7'b1110011, 0, 0, 1'b0);
      run_instr(R_ALU, TO, 0, 1'b0);
      run_instr(I_ALU, TO - 1, 0, 1'b0);
      run_instr(STORE, 1, TO, 1'b0);
      run_instr(LOAD, 0, TO - 1, 1'b0);

      for (int n = 0; n < 200; n++) begin
         if ($urandom_range(0, 7) == 0) begin
            do op = 7'($urandom); while (is_legal(op));
         end else begin
            op = legal_ops[$urandom_range(0, 5)];
         end
         wf = ($urandom_range(0, 3) == 0) ? $urandom_range(0, TO + 1) : 0;
         wm = ($urandom_range(0, 2) == 0) ? $urandom_range(0, TO + 1) : 0;
         run_instr(op, wf, wm, 1'($urandom));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Multi-cycle sequencer for the RV32 datapath subset R_ALU (0110011), I_ALU (0010011), LOAD (0000011), STORE (0100011), BRANCH (1100011) and JAL (1101111).
- Drives per-state strobes for PC, IR, MDR, register file, ALU and a shared instruction/data memory port.
- The memory port uses a req/ready handshake with wait states and a timeout.
- Sits between the IR opcode field and the shared datapath, and replaces single-cycle decode for the multi-cycle build.

Parameters:
MEM_TIMEOUT, 16, max cycles mem_req may stay high without mem_ready before trapping (legal range 1..255).

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous reset, active-high
opcode  input  7  IR[6:0] from datapath; valid from DECODE onward
branch_taken  input  1  comparator result from datapath; sampled in EXEC
mem_ready  input  1  memory completes the current access this cycle
mem_req  output  1  memory access request
mem_we  output  1  write enable, qualifies mem_req
addr_sel  output  1  0 = PC, 1 = ALU result
ir_write  output  1  load IR (and OLD_PC) from memory data/PC
mdr_write  output  1  load MDR from memory read data
pc_write  output  1  update PC
pc_src  output  1  0 = PC+4, 1 = branch/jump target (OLD_PC+imm)
alu_op  output  3  000 add, 001 branch cmp, 010 R-type, 011 I-type, 100 idle
alu_src  output  1  0 = rs2, 1 = immediate
imm_sel  output  2  00 I/L, 01 S, 10 B, 11 J
reg_write  output  1  register file write strobe
wb_sel  output  2  00 ALU, 01 MDR, 10 OLD_PC+4
halted  output  1  sticky trap indication
state_o  output  3  current state code, for debug/verification

Behaviour:
- States and codes: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5. Codes 6 and 7 are illegal and go to TRAP.
- Reset:
  - rst high at a clock edge gives state=FETCH, wait counter=0 and halted=0.
  - While rst is high, every output is 0 except alu_op=100; state_o reads 0.
  - rst high mid-access abandons the access; no strobe fires in that cycle.
- Output style: Moore outputs decoded from the registered state plus opcode. Exceptions: mem_ready-qualified strobes, and the BRANCH pc_write, which is gated by branch_taken. Default for every strobe is 0, with alu_op=100, imm_sel=00, wb_sel=00.
- FETCH:
  - mem_req=1, mem_we=0, addr_sel=0.
  - On mem_ready: ir_write=1, pc_write=1, pc_src=0, then go to DECODE. Otherwise stay.
- DECODE:
  - imm_sel is driven from opcode.
  - Opcode not in the legal set goes to TRAP; legal opcodes go to EXEC.
- EXEC:
  - R_ALU: alu_op=010, alu_src=0, go to WB.
  - I_ALU: alu_op=011, alu_src=1, go to WB.
  - LOAD/STORE: alu_op=000, alu_src=1, imm_sel=00 or 01, go to MEM.
  - BRANCH: alu_op=001, alu_src=0, imm_sel=10, pc_src=1, pc_write=branch_taken, go to FETCH.
  - JAL: imm_sel=11, pc_src=1, pc_write=1, reg_write=1, wb_sel=10, go to FETCH.
- MEM:
  - mem_req=1, addr_sel=1, mem_we=(opcode==STORE), alu_op=000, alu_src=1. imm_sel stays as in EXEC (00 for LOAD, 01 for STORE) so the address is stable.
  - On mem_ready: LOAD asserts mdr_write=1 and goes to WB; STORE goes to FETCH.
- WB:
  - reg_write=1; wb_sel=01 for LOAD, 00 otherwise.
  - alu_op and alu_src are held as in EXEC so the ALU result is stable.
  - Go to FETCH.
- TRAP: halted=1, all strobes 0, mem_req=0. Absorbing state; only rst exits.
- Handshake:
  - Once mem_req rises in FETCH or MEM, it and addr_sel/mem_we stay constant until the mem_ready cycle, TRAP, or rst.
  - mem_ready while mem_req=0 is ignored.
  - Memory returns read data in the mem_ready cycle.
- Timeout:
  - An 8-bit wait counter clears on state entry and increments each FETCH/MEM cycle with mem_ready=0.
  - When the counter equals MEM_TIMEOUT-1 and mem_ready=0, the next state is TRAP.
  - mem_ready in that same cycle wins, and the access completes normally.
- Latency with zero-wait memory (mem_ready constantly 1), cycles from FETCH entry back to FETCH:
  - R/I: 4
  - LOAD: 5
  - STORE: 4
  - BRANCH: 3
  - JAL: 3
- Each memory wait cycle adds 1.

Test Plan:
- Reset: hold rst for 3 cycles with mem_ready=1 -> all strobes 0, state_o=0; first cycle after release shows mem_req=1, addr_sel=0.
- ADD flow: mem_ready=1, opcode=0110011 -> state_o 0,1,2,4,0. Exactly one ir_write and one pc_write (pc_src=0); alu_op=010 in EXEC; reg_write=1 with wb_sel=00 in WB only.
- LOAD with 2 wait cycles in MEM, opcode=0000011 -> mem_req=1, addr_sel=1, mem_we=0 held for 3 cycles; mdr_write=1 only in the ready cycle; WB has wb_sel=01; total 7 cycles.
- STORE then BRANCH:
  - STORE (0100011) with mem_ready=1 -> mem_we=1 in MEM, no reg_write, 4 cycles.
  - BRANCH (1100011) with branch_taken=1 -> pc_write=1, pc_src=1 in EXEC.
  - BRANCH with branch_taken=0 -> no pc_write in EXEC.
- JAL (1101111) -> EXEC asserts pc_write=1, pc_src=1, reg_write=1, wb_sel=10, imm_sel=11, then returns to FETCH; 3 cycles.
- Faults:
  - opcode=1110011 -> TRAP after DECODE; halted=1 and stays high for 20 cycles.
  - Separately, MEM_TIMEOUT=4 with mem_ready=0 in FETCH -> TRAP on the 5th cycle and mem_req drops.
  - With MEM_TIMEOUT=4, mem_ready on the 4th cycle -> normal DECODE.
